phase_differentiator: RTL and testbench

PHASE_DIFFERENTIATOR -- requirements
Module: phase_differentiator

---
 rtl/phase_differentiator.sv | 120 ++++++++++++
 tb/tb_phase_differentiator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/phase_differentiator.sv
// Phase differentiator: turns a stream of modular phase samples into phase
// increments. Define PHASE_DIFF_AVG_EN to average 2^AVG_LOG2 deltas per output.
module phase_differentiator #(
  parameter int PHASE_WIDTH = 32,
  parameter int AVG_LOG2    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PHASE_WIDTH-1:0] phase_in,
  input  logic                   resync,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PHASE_WIDTH-1:0] freq_out
);

  localparam int SUM_W = PHASE_WIDTH + AVG_LOG2;

  typedef enum logic {PRIME, RUN} state_t;

  state_t                        state, state_nxt;
  logic                          accept;
  logic                          run_accept;
  logic                          produce;
  logic signed [PHASE_WIDTH-1:0] delta;
  logic signed [PHASE_WIDTH-1:0] result;
  logic [PHASE_WIDTH-1:0]        ref_p0;
  logic [PHASE_WIDTH-1:0]        freq_p1;
  logic                          vld_p1;

  // Arithmetic shift of the window sum, truncated back to the phase width.
  function automatic logic signed [PHASE_WIDTH-1:0] avg_scale(
    input logic signed [SUM_W-1:0] sum
  );
    logic signed [SUM_W-1:0] shifted;
    shifted = sum >>> AVG_LOG2;
    return shifted[PHASE_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= PRIME;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b1;
    accept     = 1'b0;
    run_accept = 1'b0;
    case (state)
      PRIME: in_ready = 1'b1;
      RUN:   in_ready = !vld_p1 || out_ready;
      default: in_ready = 1'b1;
    endcase
    if (rst) in_ready = 1'b1;
    accept     = in_valid && in_ready;
    run_accept = accept && (state == RUN) && !resync;
    if (accept)      state_nxt = RUN;
    else if (resync) state_nxt = PRIME;
  end

  // Modular subtraction handles phase wrap-around for free.
  assign delta = $signed(phase_in - ref_p0);

`ifdef PHASE_DIFF_AVG_EN
  logic signed [SUM_W-1:0] sum_p0, sum_nxt;
  logic [AVG_LOG2:0]       cnt_p0, cnt_nxt;
  logic                    window_done;

  always_comb begin
    sum_nxt     = sum_p0 + {{AVG_LOG2{delta[PHASE_WIDTH-1]}}, delta};
    cnt_nxt     = cnt_p0 + (AVG_LOG2+1)'(1);
    window_done = (cnt_nxt == (AVG_LOG2+1)'(1 << AVG_LOG2));
    result      = avg_scale(sum_nxt);
    produce     = run_accept && window_done;
  end

  always_ff @(posedge clk) begin
    if (rst || resync) begin
      sum_p0 <= '0;
      cnt_p0 <= '0;
    end else if (run_accept) begin
      if (window_done) begin
        sum_p0 <= '0;
        cnt_p0 <= '0;
      end else begin
        sum_p0 <= sum_nxt;
        cnt_p0 <= cnt_nxt;
      end
    end
  end
`else
  always_comb begin
    result  = delta;
    produce = run_accept;
  end
`endif

  // Stage p0 -> p1: reference capture and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_p0  <= '0;
      freq_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (accept) ref_p0 <= phase_in;
      if (produce) begin
        freq_p1 <= result;
        vld_p1  <= 1'b1;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign freq_out  = freq_p1;

endmodule

// File: tb/tb_phase_differentiator.sv
// Self-checking bench for phase_differentiator: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_phase_differentiator;
  localparam int W  = 32;
  localparam int AL = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] phase_in = '0;
  logic         resync = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] freq_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit           m_run, m_vld;
  logic [W-1:0] m_ref, m_q;
  longint       m_sum;
  int           m_cnt;

  phase_differentiator #(.PHASE_WIDTH(W), .AVG_LOG2(AL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .phase_in(phase_in), .resync(resync), .out_valid(out_valid),
    .out_ready(out_ready), .freq_out(freq_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input bit r, input bit iv, input logic [W-1:0] ph,
                      input bit rs, input bit ordy);
    bit           exp_rdy, acc, prod;
    logic [W-1:0] d, val;
    longint       s;
    @(negedge clk);
    rst = r; in_valid = iv; phase_in = ph; resync = rs; out_ready = ordy;
    #1;
    exp_rdy = r || !m_run || !m_vld || ordy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = iv && exp_rdy;
    @(posedge clk);
    if (r) begin
      m_run = 0; m_vld = 0; m_q = '0; m_ref = '0; m_sum = 0; m_cnt = 0;
    end else begin
      prod = 0;
      val  = m_q;
      if (acc && m_run && !rs) begin
        d = ph - m_ref;
`ifdef PHASE_DIFF_AVG_EN
        s = m_sum + longint'($signed(d));
        if (m_cnt + 1 == (1 << AL)) begin
          prod = 1; val = W'(s >>> AL); m_sum = 0; m_cnt = 0;
        end else begin
          m_sum = s; m_cnt = m_cnt + 1;
        end
`else
        s = 0;
        prod = 1; val = d;
`endif
      end
      if (rs) begin m_sum = 0; m_cnt = 0; end
      if (prod) begin m_vld = 1; m_q = val; end
      else if (ordy) m_vld = 0;
      if (acc) begin m_ref = ph; m_run = 1; end
      else if (rs) m_run = 0;
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    if (m_vld || r) chk("freq_out", freq_out, m_q);
  endtask

  initial begin
    logic [W-1:0] ph;
    step(1, 0, 0, 0, 1);
    step(1, 1, 32'h55, 0, 1);
    chk("reset_freq", freq_out, 0);
`ifndef PHASE_DIFF_AVG_EN
    // Basic increments
    step(0, 1, 0, 0, 1);
    chk("first_no_out", {31'd0, out_valid}, 0);
    step(0, 1, 100, 0, 1);
    chk("inc100_a", freq_out, 100);
    step(0, 1, 200, 0, 1);
    chk("inc100_b", freq_out, 100);
    step(0, 1, 300, 0, 1);
    chk("inc100_c", freq_out, 100);
    step(0, 0, 0, 0, 1);
    // Wrap-around
    step(0, 1, 32'hFFFF_FFF0, 1, 1);
    step(0, 1, 32'h0000_0010, 0, 1);
    chk("wrap_pos", freq_out, 32'h20);
    step(0, 1, 32'h0000_0000, 0, 1);
    chk("wrap_neg", freq_out, 32'hFFFF_FFF0);
    step(0, 0, 0, 0, 1);
    // Backpressure
    step(0, 1, 0, 1, 0);
    step(0, 1, 5, 0, 0);
    step(0, 1, 9, 0, 0);
    chk("bp_hold", freq_out, 5);
    chk("bp_ready", {31'd0, in_ready}, 0);
    step(0, 1, 9, 0, 0);
    step(0, 1, 9, 0, 1);
    chk("bp_release", freq_out, 4);
    step(0, 0, 0, 0, 1);
    // Resync between samples
    step(0, 1, 10, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 50, 0, 1);
    chk("resync_no_out", {31'd0, out_valid}, 0);
    step(0, 1, 60, 0, 1);
    chk("resync_next", freq_out, 10);
    // Reset with pending output
    step(1, 0, 0, 0, 0);
    chk("rst_drop", {31'd0, out_valid}, 0);
    step(0, 1, 7, 0, 1);
    chk("rst_prime", {31'd0, out_valid}, 0);
    step(0, 1, 9, 0, 1);
    chk("rst_after", freq_out, 2);
`else
    // Alternating 3/5 increments average to 4
    ph = 32'd1000;
    step(0, 1, ph, 0, 1);
    for (int i = 1; i <= 16; i++) begin
      ph = ph + ((i % 2) ? 32'd3 : 32'd5);
      step(0, 1, ph, 0, 1);
      if (i % 4 == 0) chk("avg_4", freq_out, 4);
    end
    step(0, 0, 0, 0, 1);
    // Negative increments
    ph = 32'd20;
    step(0, 1, ph, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      ph = ph - 32'd4;
      step(0, 1, ph, 0, 1);
    end
    chk("avg_neg", freq_out, 32'hFFFF_FFFC);
`endif
    // Randomized traffic
    ph = $urandom;
    for (int i = 0; i < 400; i++) begin
      ph = (($urandom % 4) == 0) ? W'($urandom) : ph + W'($urandom_range(0, 64)) - 32'd20;
      step(($urandom % 64) == 0, ($urandom % 4) != 0, ph,
           ($urandom % 16) == 0, ($urandom % 3) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
